multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle main control FSM for the mini MIPS datapath. Sequences fetch, decode, execute, memory and write-back over several clocks per instruction.
- Drives the datapath mux selects and register/memory enables, plus the 3-bit alu_op consumed by the ALU control block. alu_op 111 means "decode from funct"; any other value is passed to the ALU directly.
- Handles a ready handshake to the shared instruction/data memory, a run/idle gate, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- OPC_W, 4, opcode field width

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- run  input  1  1 = execute instructions; sampled in IDLE and at instruction end
- opcode  input  OPC_W  IR opcode field, valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write at this edge
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if branch condition true
- branch_ne  output  1  0 = beq (load on zero), 1 = bne (load on not-zero)
- ir_write  output  1  IR load
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- reg_write  output  1  register file write enable
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR
- alu_src_a  output  1  0 = PC, 1 = regA
- alu_src_b  output  2  00 regB, 01 const 1, 10 sign-ext imm, 11 zero-ext imm
- alu_op  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 use funct
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  output  1  sticky illegal-opcode flag
- state  output  4  current state encoding, for debug
- instr_count  output  CNT_W  retired instructions, wraps

Behaviour:
- Opcodes: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 lw, 0101 sw, 0110 beq, 0111 bne, 1000 j. All others are illegal.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, WB_ALU 5, MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, TRAP 12.
- Reset: state = IDLE, instr_count = 0, illegal_op = 0, every control output 0.
- Reset wins over all other events, including a pending mem handshake. mem_read/mem_write drop in the cycle after reset is sampled.
- Default value of every control output is 0 unless listed for the state.
- IDLE: all controls 0. Goes to FETCH when run = 1.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 010.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - alu_src_a = 0, alu_src_b = 10, alu_op = 010 (branch target into ALUOut).
  - Next state: R-type → EXEC_R; addi/andi/ori → EXEC_I; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP; illegal → TRAP.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 111. Goes to WB_ALU.
- EXEC_I:
  - alu_src_a = 1.
  - addi: alu_src_b = 10, alu_op = 010.
  - andi: alu_src_b = 11, alu_op = 000.
  - ori: alu_src_b = 11, alu_op = 001.
  - Goes to WB_ALU.
- WB_ALU: reg_write = 1, mem_to_reg = 0, reg_dst = 1 for R-type, 0 for immediates. Retires.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 010. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires.
- MEM_WR: mem_write = 1, i_or_d = 1. Holds until mem_ready = 1, then retires.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_write_cond = 1, pc_source = 01, branch_ne = 1 for bne. Retires.
- JUMP: pc_write = 1, pc_source = 10. Retires.
- Retire:
  - instr_count increments by 1 on the transition out of the retiring state, wrapping at 2^CNT_W to 0.
  - Next state is FETCH if run = 1, else IDLE.
- TRAP: illegal_op is set on entry and stays 1 until reset. All controls 0. TRAP is absorbing; instr_count does not increment.
- run is ignored mid-instruction; it is sampled only in IDLE and at retire.
- mem_read/mem_write are never both 1. Request signals stay stable while waiting for mem_ready.

Test Plan:
- Reset then run = 1, R-type (opcode 0000), mem_ready = 1 always → states 1,2,3,5,1. alu_op = 111 in EXEC_R. reg_write = 1 and reg_dst = 1 in WB_ALU. instr_count = 1.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_RD → FETCH held 4 cycles, ir_write = 1 only in the last. mem_read held through MEM_RD. Total 10 cycles to retire. mem_to_reg = 1 in MEM_WB.
- beq then bne → BRANCH asserts pc_write_cond = 1, alu_op = 110, pc_source = 01. branch_ne = 0 for beq, 1 for bne.
- Opcode 1111 → DECODE then TRAP (state = 12). illegal_op = 1 and all controls 0 for 20 cycles. instr_count unchanged. Reset clears both.
- Reset asserted during MEM_WR with mem_ready = 0 → next cycle state = 0, mem_write = 0, instr_count = 0.
- CNT_W = 4, run 16 j instructions → instr_count wraps 15 → 0. Drop run before the last retire → state = IDLE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the mini MIPS datapath (fetch/decode/execute/mem/wb).
// Latency: 3-5 clocks per instruction plus memory wait cycles; controls are Moore except FETCH ir/pc write.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with stable requests until mem_ready; run gates instruction start.
module multicycle_control #(
  parameter int CNT_W = 16,
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(8);

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  state_t cur, nxt;
  logic   retire;

  assign state = cur;

  // State register, retired-instruction counter and sticky trap flag; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + 1'b1;
      if (nxt == S_TRAP) illegal_op <= 1'b1;
    end
  end

  // Next-state and control decode; every output defaults to 0 and only the listed state raises it.
  always_comb begin
    nxt           = cur;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        // PC+1 computed in the ALU while the instruction is read.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_R:                     nxt = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = S_EXEC_I;
          OP_LW, OP_SW:             nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           nxt = S_BRANCH;
          OP_J:                     nxt = S_JUMP;
          default:                  nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = ALU_FUNCT;
        nxt       = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ANDI: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_AND;
          end
          OP_ORI: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_OR;
          end
          default: begin
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
          end
        endcase
        nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R);
        retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        nxt       = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
    // run is only consulted at instruction boundaries.
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int CW = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  logic          clk, reset, run, mem_ready;
  logic [3:0]    opcode;
  logic          pc_write, pc_write_cond, branch_ne, ir_write, mem_read, mem_write, i_or_d;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0]    alu_src_b, pc_source;
  logic [2:0]    alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  ctl_t          got;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  bit exp_ill = 0;
  bit exp_idle = 1;

  multicycle_control #(.CNT_W(CW), .OPC_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  assign got = {pc_write, pc_write_cond, branch_ne, ir_write, mem_read, mem_write, i_or_d,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of the model: drive inputs, compare everything the spec fixes, advance to the next negedge.
  task automatic step(input logic [3:0] es, input ctl_t ec, input logic mr, input logic rn);
    logic [CW-1:0] ecnt;
    ecnt = CW'(exp_cnt % (1 << CW));
    mem_ready = mr;
    run       = rn;
    #1;
    n_cmp++;
    assert (state === es) else begin
      n_err++; $error("FAIL state: observed %0d expected %0d", state, es);
    end
    n_cmp++;
    assert (got === ec) else begin
      n_err++; $error("FAIL ctl in state %0d: observed %h expected %h", es, got, ec);
    end
    n_cmp++;
    assert (instr_count === ecnt) else begin
      n_err++; $error("FAIL instr_count: observed %0d expected %0d", instr_count, ecnt);
    end
    n_cmp++;
    assert (illegal_op === exp_ill) else begin
      n_err++; $error("FAIL illegal_op: observed %0b expected %0b", illegal_op, exp_ill);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 4'($urandom);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    exp_cnt  = 0;
    exp_ill  = 0;
    exp_idle = 1;
  endtask

  // Expected behaviour of one whole instruction, written from the opcode table.
  // fw/mw: cycles mem_ready stays low in FETCH and in the data access.
  task automatic do_instr(input logic [3:0] opc, input int fw, input int mw,
                          input logic run_next, input bit abort_in_wr);
    ctl_t c;
    if (exp_idle) begin
      c = '0;
      step(4'd0, c, rbit(), 1'b1);
    end
    opcode = 4'($urandom);
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
      step(4'd1, c, 1'b0, rbit());
    end
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
    c.ir_write = 1; c.pc_write = 1;
    step(4'd1, c, 1'b1, rbit());
    opcode = opc;
    c = '0; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
    step(4'd2, c, rbit(), rbit());
    case (opc)
      4'd0: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = 3'b111;
        step(4'd3, c, rbit(), rbit());
        c = '0; c.reg_write = 1; c.reg_dst = 1;
        step(4'd5, c, rbit(), run_next);
      end
      4'd1, 4'd2, 4'd3: begin
        c = '0; c.alu_src_a = 1;
        c.alu_src_b = (opc == 4'd1) ? 2'b10 : 2'b11;
        c.alu_op    = (opc == 4'd1) ? 3'b010 : (opc == 4'd2) ? 3'b000 : 3'b001;
        step(4'd4, c, rbit(), rbit());
        c = '0; c.reg_write = 1;
        step(4'd5, c, rbit(), run_next);
      end
      4'd4, 4'd5: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
        step(4'd6, c, rbit(), rbit());
        c = '0; c.i_or_d = 1;
        if (opc == 4'd4) c.mem_read = 1; else c.mem_write = 1;
        for (int i = 0; i < mw; i++) step((opc == 4'd4) ? 4'd7 : 4'd9, c, 1'b0, rbit());
        if (abort_in_wr) return;
        if (opc == 4'd4) begin
          step(4'd7, c, 1'b1, rbit());
          c = '0; c.reg_write = 1; c.mem_to_reg = 1;
          step(4'd8, c, rbit(), run_next);
        end else begin
          step(4'd9, c, 1'b1, run_next);
        end
      end
      4'd6, 4'd7: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_write_cond = 1; c.pc_source = 2'b01;
        c.branch_ne = (opc == 4'd7);
        step(4'd10, c, rbit(), run_next);
      end
      4'd8: begin
        c = '0; c.pc_write = 1; c.pc_source = 2'b10;
        step(4'd11, c, rbit(), run_next);
      end
      default: begin
        exp_ill = 1;
        c = '0;
        for (int i = 0; i < 20; i++) begin
          opcode = 4'($urandom);
          step(4'd12, c, rbit(), rbit());
        end
        return;
      end
    endcase
    exp_cnt++;
    exp_idle = !run_next;
  endtask

  initial begin
    ctl_t z;
    z = '0;
    do_reset();
    // Reset state with run low: stays idle.
    step(4'd0, z, 1'b1, 1'b0);
    step(4'd0, z, 1'b0, 1'b0);

    // R-type, no memory stalls.
    do_instr(4'd0, 0, 0, 1'b1, 1'b0);
    // lw: 3 fetch stalls and 2 read stalls.
    do_instr(4'd4, 3, 2, 1'b1, 1'b0);
    // beq then bne.
    do_instr(4'd6, 0, 0, 1'b1, 1'b0);
    do_instr(4'd7, 1, 0, 1'b0, 1'b0);
    // Randomised mix of legal instructions.
    for (int k = 0; k < 40; k++)
      do_instr(4'($urandom_range(0, 8)), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 3) != 0), 1'b0);

    // Reset during a stalled store; counter must be nonzero first.
    do_reset();
    do_instr(4'd1, 0, 0, 1'b1, 1'b0);
    do_instr(4'd5, 0, 2, 1'b1, 1'b1);
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    assert (state === 4'd0) else begin
      n_err++; $error("FAIL reset_in_memwr state: observed %0d expected 0", state);
    end
    n_cmp++;
    assert (mem_write === 1'b0) else begin
      n_err++; $error("FAIL reset_in_memwr mem_write: observed %0b expected 0", mem_write);
    end
    n_cmp++;
    assert (instr_count === '0) else begin
      n_err++; $error("FAIL reset_in_memwr instr_count: observed %0d expected 0", instr_count);
    end
    @(negedge clk);

    // Illegal opcode traps; then reset clears the flag and counter.
    do_reset();
    do_instr(4'd3, 0, 0, 1'b1, 1'b0);
    do_instr(4'd15, 0, 0, 1'b1, 1'b0);
    do_reset();
    step(4'd0, z, 1'b0, 1'b0);
    do_instr(4'($urandom_range(9, 15)), 2, 0, 1'b1, 1'b0);
    do_reset();

    // Sixteen jumps wrap the 4-bit counter; run drops at the last retire.
    for (int k = 0; k < 16; k++) do_instr(4'd8, 0, 0, 1'(k != 15), 1'b0);
    step(4'd0, z, 1'b0, 1'b0);
    step(4'd0, z, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
